// File: rtl/srt_div_pkg.sv
// srt_div_pkg: shared constants, state encoding and operand type for the SRT divider.
package srt_div_pkg;

    localparam int ITERS_DEF = 25;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int RES_W     = 28;

    localparam logic [EXP_W-1:0] BIAS = 8'd127;
    localparam logic [31:0]      QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREP    = 3'd1,
        ST_ITERATE = 3'd2,
        ST_FIX     = 3'd3,
        ST_NORM    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

endpackage

// File: rtl/srt_norm_pack.sv
// srt_norm_pack: picks the 24-bit mantissa window from the corrected quotient and packs the result.
// Overflow/underflow clamping is present only when SRT_DIV_SPECIAL_EN is defined.
module srt_norm_pack
    import srt_div_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,
    input  logic [MAN_W+1:0]  q_i,
    output logic [31:0]       result_o
);

    logic signed [9:0] exp_adj_s;
    logic [MAN_W-1:0]  frac_s;

    // Quotient MSB position selects the mantissa window and the exponent correction.
    always_comb begin
        if (q_i[MAN_W+1]) begin
            frac_s    = q_i[MAN_W:1];
            exp_adj_s = exp_i;
        end else begin
            frac_s    = q_i[MAN_W-1:0];
            exp_adj_s = exp_i - 10'sd1;
        end
    end

`ifdef SRT_DIV_SPECIAL_EN
    // Clamp out-of-range exponents to signed infinity or signed zero.
    always_comb begin
        if (exp_adj_s >= 10'sd255) begin
            result_o = {sign_i, 8'hFF, 23'h0};
        end else if (exp_adj_s <= 10'sd0) begin
            result_o = {sign_i, 31'h0};
        end else begin
            result_o = {sign_i, exp_adj_s[EXP_W-1:0], frac_s};
        end
    end
`else
    logic unused_exp_s;
    assign unused_exp_s = ^exp_adj_s[9:EXP_W];
    assign result_o     = {sign_i, exp_adj_s[EXP_W-1:0], frac_s};
`endif

endmodule

// File: rtl/srt_div_seq.sv
// srt_div_seq: sequential radix-2 SRT single-precision divider, result truncated toward zero.
// SRT_DIV_SPECIAL_EN adds operand classification, special-value short-cuts and div_by_zero.
module srt_div_seq
    import srt_div_pkg::*;
#(
    parameter int ITERS = ITERS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic        div_by_zero,
    output logic        busy
);

    localparam int CNT_W = $clog2(ITERS);
    localparam logic signed [RES_W-1:0] HALF_POS = 28'sh200_0000;
    localparam logic signed [RES_W-1:0] HALF_NEG = 28'shE00_0000;

    state_e                   state_q;
    fp_t                      a_q, b_q;
    logic                     sign_q;
    logic signed [9:0]        exp_q;
    logic signed [RES_W-1:0]  w_q, d_q, w_d, w2_s;
    logic [ITERS-1:0]         qp_q, qn_q, qfix_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     in_ready_q, out_valid_q, busy_q;
    logic [31:0]              quotient_q, packed_s;
    logic                     digit_pos_s, digit_neg_s, sign_s;

    assign sign_s = a_q.sign ^ b_q.sign;

    // Digit selection on the doubled residual, then the w <- 2w - q*d recurrence.
    always_comb begin
        w2_s        = w_q <<< 1;
        digit_pos_s = (w2_s >= HALF_POS);
        digit_neg_s = (w2_s < HALF_NEG);
        if (digit_pos_s) begin
            w_d = w2_s - d_q;
        end else if (digit_neg_s) begin
            w_d = w2_s + d_q;
        end else begin
            w_d = w2_s;
        end
    end

`ifdef SRT_DIV_SPECIAL_EN
    logic        dbz_q, special_s, special_dbz_s;
    logic [31:0] special_res_s;
    logic        a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;

    // Denormals count as zero; specials resolve directly to their packed result.
    always_comb begin
        a_zero_s      = (a_q.exp == 8'h00);
        b_zero_s      = (b_q.exp == 8'h00);
        a_inf_s       = (a_q.exp == 8'hFF) && (a_q.man == 23'h0);
        b_inf_s       = (b_q.exp == 8'hFF) && (b_q.man == 23'h0);
        a_nan_s       = (a_q.exp == 8'hFF) && (a_q.man != 23'h0);
        b_nan_s       = (b_q.exp == 8'hFF) && (b_q.man != 23'h0);
        special_s     = 1'b1;
        special_dbz_s = 1'b0;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            special_res_s = QNAN;
        end else if (a_inf_s) begin
            special_res_s = {sign_s, 8'hFF, 23'h0};
        end else if (b_zero_s) begin
            special_res_s = {sign_s, 8'hFF, 23'h0};
            special_dbz_s = 1'b1;
        end else if (a_zero_s || b_inf_s) begin
            special_res_s = {sign_s, 31'h0};
        end else begin
            special_s     = 1'b0;
            special_res_s = QNAN;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    srt_norm_pack u_norm_pack (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .q_i      (qfix_q),
        .result_o (packed_s)
    );

    // Control FSM together with the residual, quotient and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            quotient_q  <= 32'h0;
            a_q         <= fp_t'(32'h0);
            b_q         <= fp_t'(32'h0);
            sign_q      <= 1'b0;
            exp_q       <= 10'sd0;
            w_q         <= 28'sd0;
            d_q         <= 28'sd0;
            qp_q        <= ITERS'(0);
            qn_q        <= ITERS'(0);
            qfix_q      <= ITERS'(0);
            cnt_q       <= CNT_W'(0);
`ifdef SRT_DIV_SPECIAL_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= dividend;
                        b_q        <= divisor;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    sign_q  <= sign_s;
                    exp_q   <= $signed({2'b00, a_q.exp} - {2'b00, b_q.exp} + {2'b00, BIAS});
                    // w = ma/2^25 and d = mb/2^24 on a 26-bit fraction grid.
                    w_q     <= $signed({3'b000, 1'b1, a_q.man, 1'b0});
                    d_q     <= $signed({2'b00, 1'b1, b_q.man, 2'b00});
                    qp_q    <= ITERS'(0);
                    qn_q    <= ITERS'(0);
                    cnt_q   <= CNT_W'(0);
                    state_q <= ST_ITERATE;
`ifdef SRT_DIV_SPECIAL_EN
                    if (special_s) begin
                        quotient_q  <= special_res_s;
                        dbz_q       <= special_dbz_s;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`endif
                end
                ST_ITERATE: begin
                    w_q   <= w_d;
                    qp_q  <= {qp_q[ITERS-2:0], digit_pos_s};
                    qn_q  <= {qn_q[ITERS-2:0], digit_neg_s};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // A negative final residual means the redundant quotient overshot by one ulp.
                    qfix_q  <= qp_q - qn_q - ITERS'(w_q[RES_W-1]);
                    state_q <= ST_NORM;
                end
                ST_NORM: begin
                    quotient_q  <= packed_s;
                    out_valid_q <= 1'b1;
`ifdef SRT_DIV_SPECIAL_EN
                    dbz_q       <= 1'b0;
`endif
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_srt_div_seq.sv
// tb_srt_div_seq: table-driven and random checks of srt_div_seq against a truncating integer reference.
module tb_srt_div_seq;

    localparam int LAT    = 29;
    localparam int LAT_SP = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
    logic [31:0] dividend, divisor, quotient;

    int n_err    = 0;
    int n_checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    srt_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] num, den, qi;
        logic [22:0] frac;
        int          e;
        num = {16'd0, 1'b1, a[22:0], 24'd0};
        den = {40'd0, 1'b1, b[22:0]};
        qi  = num / den;
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (qi[24]) begin
            frac = qi[23:1];
        end else begin
            frac = qi[22:0];
            e    = e - 1;
        end
        return {a[31] ^ b[31], 8'(e), frac};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] ex;
        ex = 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), ex, 23'($urandom())};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                         input logic ed, input int el, input int hold);
        exp_t e;
        int   k;
        @(negedge clk);
        out_ready = (hold == 0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom();
        divisor  = $urandom();
        sb.push_back('{er, ed, el});
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!out_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                dividend = $urandom();
            end
        end while (!out_valid && k < 100);
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("latency", 32'(k), 32'(e.lat));
        chk("quotient", quotient, e.res);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_quotient", quotient, e.res);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_busy", 32'(busy), 32'd1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("bp_in_ready_after", 32'(in_ready), 32'd1);
            chk("bp_out_valid_after", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 32'h0;
        divisor   = 32'h0;

        vecs.push_back('{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, LAT});
        vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, LAT});
        vecs.push_back('{32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000, 1'b0, LAT});
        vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, LAT});
        vecs.push_back('{32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, 1'b0, LAT});
        vecs.push_back('{32'h3FFF_FFFF, 32'h3F80_0000, 32'h3FFF_FFFF, 1'b0, LAT});
        vecs.push_back('{32'h3F80_0000, 32'h3FFF_FFFF, 32'h3F00_0000, 1'b0, LAT});
`ifdef SRT_DIV_SPECIAL_EN
        vecs.push_back('{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, LAT_SP});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, LAT_SP});
        vecs.push_back('{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, LAT_SP});
        vecs.push_back('{32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0, LAT_SP});
`endif

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", quotient, 32'h0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz, vecs[i].lat, 0);
        end

        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, LAT, 10);

        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'h40C0_0000;
        divisor  = 32'h4000_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, LAT, 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = rnd_fp();
            b = rnd_fp();
            do_op(a, b, ref_div(a, b), 1'b0, LAT, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
